bj_predict_unit: RTL and testbench

Parametrised branch/jump unit for the pipelined RV32IM core. It combines a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters, which supply a taken/target prediction to IF. It resolves branches and jumps in EX and raises a flush with the correct redirect PC on a mispredict. It also keeps saturating performance counters for resolved control instructions and mispredicts.

---
 rtl/bj_predict_unit.sv | 189 ++++++++++++++++++
 tb/tb_bj_predict_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bj_predict_unit.sv
// bj_predict_unit
//   Branch/jump unit for the pipelined RV32IM core. A direct-mapped BTB with
//   2-bit saturating direction counters supplies a taken/target prediction to
//   IF. Control instructions are resolved in EX. On a mispredict, FLUSH is
//   raised together with the correct redirect PC. Saturating performance
//   counters track resolved control instructions and mispredicts.
//
// Ports
//   CLK, RESET         clock; synchronous active-high reset
//   IF_PC              fetch PC to look up
//   PRED_TAKEN/TARGET  combinational prediction for IF_PC (target 0 if not taken)
//   EX_*               resolution inputs for the instruction in EX, including the
//                      prediction that was carried down the pipe with it
//   FLUSH, REDIRECT_PC mispredict indication and correct next PC
//   BRANCH_COUNT       resolved control instructions (saturating)
//   MISPREDICT_COUNT   FLUSH cycles (saturating)
module bj_predict_unit #(
    parameter int XLEN       = 32,
    parameter int INDEX_BITS = 4,
    parameter int CNT_W      = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [XLEN-1:0]  IF_PC,
    output logic             PRED_TAKEN,
    output logic [XLEN-1:0]  PRED_TARGET,
    input  logic             EX_VALID,
    input  logic [XLEN-1:0]  EX_PC,
    input  logic [XLEN-1:0]  EX_IMM,
    input  logic [XLEN-1:0]  EX_ALU_RESULT,
    input  logic [1:0]       EX_BJ_SIGNAL,
    input  logic [2:0]       EX_FUNC3,
    input  logic             EX_ZERO,
    input  logic             EX_SIGN_BIT,
    input  logic             EX_SLTU_BIT,
    input  logic             EX_PRED_TAKEN,
    input  logic [XLEN-1:0]  EX_PRED_TARGET,
    output logic             FLUSH,
    output logic [XLEN-1:0]  REDIRECT_PC,
    output logic [CNT_W-1:0] BRANCH_COUNT,
    output logic [CNT_W-1:0] MISPREDICT_COUNT
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = XLEN - INDEX_BITS - 2;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [XLEN-1:0]    target_d [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];
    logic [CNT_W-1:0]   branch_count_q, branch_count_d;
    logic [CNT_W-1:0]   mispredict_count_q, mispredict_count_d;

    // Word-aligned PCs: bits [1:0] (and bit 0 of the jump target) never
    // reach the table.
    logic unused_bits;
    assign unused_bits = ^{IF_PC[1:0], EX_PC[1:0], EX_ALU_RESULT[0]};

    // Lookup stage: purely from registered state, so a same-cycle update
    // to the same index is seen only after the edge.
    logic [INDEX_BITS-1:0] if_idx;
    logic [TAG_W-1:0]      if_tag;
    logic                  if_hit;

    assign if_idx      = IF_PC[INDEX_BITS+1:2];
    assign if_tag      = IF_PC[XLEN-1:INDEX_BITS+2];
    assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign PRED_TAKEN  = if_hit && ctr_q[if_idx][1];
    assign PRED_TARGET = PRED_TAKEN ? target_q[if_idx] : '0;

    // Resolution stage
    logic [INDEX_BITS-1:0] ex_idx;
    logic [TAG_W-1:0]      ex_tag;
    logic                  ex_hit;
    logic                  is_branch, is_jump, cond_true, res_taken, mispredict;
    logic [XLEN-1:0]       res_target;

    assign ex_idx    = EX_PC[INDEX_BITS+1:2];
    assign ex_tag    = EX_PC[XLEN-1:INDEX_BITS+2];
    assign ex_hit    = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign is_branch = (EX_BJ_SIGNAL == 2'b01);
    assign is_jump   = EX_BJ_SIGNAL[1];

    always_comb begin
        cond_true = 1'b0;
        case (EX_FUNC3)
            3'b000:  cond_true = EX_ZERO;
            3'b001:  cond_true = ~EX_ZERO;
            3'b100:  cond_true = EX_SIGN_BIT;
            3'b101:  cond_true = ~EX_SIGN_BIT;
            3'b110:  cond_true = EX_SLTU_BIT;
            3'b111:  cond_true = ~EX_SLTU_BIT;
            default: cond_true = 1'b0;
        endcase
    end

    assign res_taken  = is_jump || (is_branch && cond_true);
    assign res_target = is_jump ? {EX_ALU_RESULT[XLEN-1:1], 1'b0} : EX_PC + EX_IMM;

    // A non-control instruction carrying a taken prediction is an alias
    // hit and must also redirect.
    assign mispredict = EX_VALID && !RESET &&
                        ((res_taken != EX_PRED_TAKEN) ||
                         (res_taken && (res_target != EX_PRED_TARGET)));

    assign FLUSH       = mispredict;
    assign REDIRECT_PC = res_taken ? res_target : EX_PC + XLEN'(4);

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (EX_VALID) begin
            if (is_jump) begin
                valid_d[ex_idx]  = 1'b1;
                tag_d[ex_idx]    = ex_tag;
                target_d[ex_idx] = res_target;
                ctr_d[ex_idx]    = 2'b11;
            end else if (is_branch) begin
                if (ex_hit) begin
                    ctr_d[ex_idx] = res_taken ? ctr_inc(ctr_q[ex_idx]) : ctr_dec(ctr_q[ex_idx]);
                    if (res_taken) begin
                        target_d[ex_idx] = res_target;
                    end
                end else if (res_taken) begin
                    valid_d[ex_idx]  = 1'b1;
                    tag_d[ex_idx]    = ex_tag;
                    target_d[ex_idx] = res_target;
                    ctr_d[ex_idx]    = 2'b10;
                end
            end else if (ex_hit) begin
                valid_d[ex_idx] = 1'b0;
            end
        end
    end

    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (EX_VALID && (EX_BJ_SIGNAL != 2'b00)) begin
            branch_count_d = cnt_sat_inc(branch_count_q);
        end
        if (mispredict) begin
            mispredict_count_d = cnt_sat_inc(mispredict_count_q);
        end
    end

    // Update stage: control state (valid, counters) is reset; tag/target
    // are don't-care while their entry is invalid.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q            <= '0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else begin
            valid_q            <= valid_d;
            ctr_q              <= ctr_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    always_ff @(posedge CLK) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

    assign BRANCH_COUNT     = branch_count_q;
    assign MISPREDICT_COUNT = mispredict_count_q;

endmodule

// File: tb/tb_bj_predict_unit.sv
module tb_bj_predict_unit;
    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             CLK = 1'b0;
    logic             RESET;
    logic [XLEN-1:0]  IF_PC;
    logic             PRED_TAKEN;
    logic [XLEN-1:0]  PRED_TARGET;
    logic             EX_VALID;
    logic [XLEN-1:0]  EX_PC, EX_IMM, EX_ALU_RESULT, EX_PRED_TARGET;
    logic [1:0]       EX_BJ_SIGNAL;
    logic [2:0]       EX_FUNC3;
    logic             EX_ZERO, EX_SIGN_BIT, EX_SLTU_BIT, EX_PRED_TAKEN;
    logic             FLUSH;
    logic [XLEN-1:0]  REDIRECT_PC;
    logic [CNT_W-1:0] BRANCH_COUNT, MISPREDICT_COUNT;

    int checks = 0;
    int errors = 0;
    logic [XLEN:0] exp_q[$];   // {flush, redirect_pc}

    bj_predict_unit #(.XLEN(XLEN), .INDEX_BITS(4), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RESET(RESET), .IF_PC(IF_PC),
        .PRED_TAKEN(PRED_TAKEN), .PRED_TARGET(PRED_TARGET),
        .EX_VALID(EX_VALID), .EX_PC(EX_PC), .EX_IMM(EX_IMM),
        .EX_ALU_RESULT(EX_ALU_RESULT), .EX_BJ_SIGNAL(EX_BJ_SIGNAL),
        .EX_FUNC3(EX_FUNC3), .EX_ZERO(EX_ZERO), .EX_SIGN_BIT(EX_SIGN_BIT),
        .EX_SLTU_BIT(EX_SLTU_BIT), .EX_PRED_TAKEN(EX_PRED_TAKEN),
        .EX_PRED_TARGET(EX_PRED_TARGET), .FLUSH(FLUSH), .REDIRECT_PC(REDIRECT_PC),
        .BRANCH_COUNT(BRANCH_COUNT), .MISPREDICT_COUNT(MISPREDICT_COUNT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_pred(input string name, input logic [XLEN-1:0] pc,
                              input logic exp_tk, input logic [XLEN-1:0] exp_tgt);
        IF_PC = pc;
        #1;
        checks++;
        assert (PRED_TAKEN === exp_tk) else begin
            errors++;
            $error("FAIL %s pred_taken: got %0b expected %0b", name, PRED_TAKEN, exp_tk);
        end
        checks++;
        assert (PRED_TARGET === exp_tgt) else begin
            errors++;
            $error("FAIL %s pred_target: got %h expected %h", name, PRED_TARGET, exp_tgt);
        end
    endtask

    task automatic check_cnt(input string name, input logic [CNT_W-1:0] exp_bc,
                             input logic [CNT_W-1:0] exp_mc);
        checks++;
        assert (BRANCH_COUNT === exp_bc) else begin
            errors++;
            $error("FAIL %s branch_count: got %0d expected %0d", name, BRANCH_COUNT, exp_bc);
        end
        checks++;
        assert (MISPREDICT_COUNT === exp_mc) else begin
            errors++;
            $error("FAIL %s mispredict_count: got %0d expected %0d", name, MISPREDICT_COUNT, exp_mc);
        end
    endtask

    // Pop the oldest expectation and compare it against the live outputs.
    task automatic check_ex(input string name);
        logic [XLEN:0] e;
        checks++;
        assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL %s scoreboard: got empty queue expected an entry", name);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            assert (FLUSH === e[XLEN]) else begin
                errors++;
                $error("FAIL %s flush: got %0b expected %0b", name, FLUSH, e[XLEN]);
            end
            if (e[XLEN]) begin
                checks++;
                assert (REDIRECT_PC === e[XLEN-1:0]) else begin
                    errors++;
                    $error("FAIL %s redirect: got %h expected %h", name, REDIRECT_PC, e[XLEN-1:0]);
                end
            end
        end
    endtask

    // Drive one EX instruction, push its expected outcome, check before the
    // edge, let it commit, then return EX to idle.
    task automatic ex_step(input string name, input logic vld, input logic [XLEN-1:0] pc,
                           input logic [XLEN-1:0] imm, input logic [XLEN-1:0] alu,
                           input logic [1:0] bj, input logic [2:0] f3,
                           input logic zero, input logic sgn, input logic sltu,
                           input logic ptk, input logic [XLEN-1:0] ptgt,
                           input logic exp_flush, input logic [XLEN-1:0] exp_redir);
        EX_VALID = vld; EX_PC = pc; EX_IMM = imm; EX_ALU_RESULT = alu;
        EX_BJ_SIGNAL = bj; EX_FUNC3 = f3; EX_ZERO = zero; EX_SIGN_BIT = sgn;
        EX_SLTU_BIT = sltu; EX_PRED_TAKEN = ptk; EX_PRED_TARGET = ptgt;
        exp_q.push_back({exp_flush, exp_redir});
        @(negedge CLK);
        check_ex(name);
        @(posedge CLK);
        #1;
        EX_VALID = 1'b0; EX_PRED_TAKEN = 1'b0; EX_BJ_SIGNAL = 2'b00;
    endtask

    initial begin
        RESET = 1'b1; IF_PC = '0; EX_VALID = 1'b0; EX_PC = '0; EX_IMM = '0;
        EX_ALU_RESULT = '0; EX_BJ_SIGNAL = 2'b00; EX_FUNC3 = 3'b000; EX_ZERO = 1'b0;
        EX_SIGN_BIT = 1'b0; EX_SLTU_BIT = 1'b0; EX_PRED_TAKEN = 1'b0; EX_PRED_TARGET = '0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;

        // Reset state
        check_pred("rst_pred", 32'h100, 1'b0, 32'h0);
        ex_step("rst_idle", 1'b0, 32'h100, 32'h40, 32'h0, 2'b01, 3'b000, 1'b1, 1'b0, 1'b0,
                1'b0, 32'h0, 1'b0, 32'h0);
        check_cnt("rst_cnt", 4'd0, 4'd0);

        // BEQ taken, unpredicted: allocate with ctr=10
        ex_step("beq_t1", 1'b1, 32'h100, 32'h40, 32'h0, 2'b01, 3'b000, 1'b1, 1'b0, 1'b0,
                1'b0, 32'h0, 1'b1, 32'h140);
        check_cnt("beq_t1", 4'd1, 4'd1);
        check_pred("beq_t1", 32'h100, 1'b1, 32'h140);

        // Not taken twice: 10->01 (flush), 01->00 (no flush)
        ex_step("beq_nt1", 1'b1, 32'h100, 32'h40, 32'h0, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0,
                1'b1, 32'h140, 1'b1, 32'h104);
        check_pred("beq_nt1", 32'h100, 1'b0, 32'h0);
        ex_step("beq_nt2", 1'b1, 32'h100, 32'h40, 32'h0, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0,
                1'b0, 32'h0, 1'b0, 32'h0);
        check_cnt("beq_nt2", 4'd3, 4'd2);
        check_pred("beq_nt2", 32'h100, 1'b0, 32'h0);

        // Two taken resolves: 00->01 still not predicted, 01->10 predicted
        ex_step("beq_t2", 1'b1, 32'h100, 32'h40, 32'h0, 2'b01, 3'b000, 1'b1, 1'b0, 1'b0,
                1'b0, 32'h0, 1'b1, 32'h140);
        check_pred("beq_t2", 32'h100, 1'b0, 32'h0);
        ex_step("beq_t3", 1'b1, 32'h100, 32'h40, 32'h0, 2'b01, 3'b000, 1'b1, 1'b0, 1'b0,
                1'b0, 32'h0, 1'b1, 32'h140);
        check_pred("beq_t3", 32'h100, 1'b1, 32'h140);
        check_cnt("beq_t3", 4'd5, 4'd4);

        // Non-control alias at 0x100: flush to PC+4, entry invalidated
        ex_step("alias", 1'b1, 32'h100, 32'h0, 32'h0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0,
                1'b1, 32'h140, 1'b1, 32'h104);
        check_cnt("alias", 4'd5, 4'd5);
        check_pred("alias", 32'h100, 1'b0, 32'h0);

        // JALR at 0x200 (same index as 0x100, different tag), bit0 cleared
        ex_step("jalr1", 1'b1, 32'h200, 32'h0, 32'h1235, 2'b10, 3'b000, 1'b0, 1'b0, 1'b0,
                1'b0, 32'h0, 1'b1, 32'h1234);
        check_pred("jalr1", 32'h200, 1'b1, 32'h1234);
        check_pred("jalr1_other_tag", 32'h100, 1'b0, 32'h0);
        ex_step("jalr2", 1'b1, 32'h200, 32'h0, 32'h2000, 2'b10, 3'b000, 1'b0, 1'b0, 1'b0,
                1'b1, 32'h1234, 1'b1, 32'h2000);
        check_pred("jalr2", 32'h200, 1'b1, 32'h2000);
        ex_step("jalr_ok", 1'b1, 32'h200, 32'h0, 32'h2001, 2'b11, 3'b000, 1'b0, 1'b0, 1'b0,
                1'b1, 32'h2000, 1'b0, 32'h0);
        check_cnt("jalr_ok", 4'd8, 4'd7);

        // Other conditions at 0x304 (index 1)
        ex_step("blt_t", 1'b1, 32'h304, 32'hFFFF_FFF8, 32'h0, 2'b01, 3'b100, 1'b0, 1'b1, 1'b0,
                1'b0, 32'h0, 1'b1, 32'h2FC);
        check_pred("blt_t", 32'h304, 1'b1, 32'h2FC);
        ex_step("bgeu_nt", 1'b1, 32'h304, 32'hFFFF_FFF8, 32'h0, 2'b01, 3'b111, 1'b0, 1'b0, 1'b1,
                1'b1, 32'h2FC, 1'b1, 32'h308);
        ex_step("f3_010", 1'b1, 32'h304, 32'hFFFF_FFF8, 32'h0, 2'b01, 3'b010, 1'b1, 1'b1, 1'b1,
                1'b0, 32'h0, 1'b0, 32'h0);
        check_cnt("f3_010", 4'd11, 4'd9);

        // EX_VALID=0 with mispredicting inputs: nothing happens
        ex_step("ex_idle", 1'b0, 32'h500, 32'h40, 32'h0, 2'b01, 3'b000, 1'b1, 1'b0, 1'b0,
                1'b0, 32'h0, 1'b0, 32'h0);
        check_cnt("ex_idle", 4'd11, 4'd9);
        check_pred("ex_idle", 32'h500, 1'b0, 32'h0);

        // Target add wraps modulo 2^32
        ex_step("bne_wrap", 1'b1, 32'hFFFF_FFF0, 32'h20, 32'h0, 2'b01, 3'b001, 1'b0, 1'b0, 1'b0,
                1'b0, 32'h0, 1'b1, 32'h10);
        check_cnt("bne_wrap", 4'd12, 4'd10);

        // BRANCH_COUNT saturation: correctly predicted not-taken branches
        for (int i = 0; i < 4; i++) begin
            ex_step("bc_sat", 1'b1, 32'h400, 32'h40, 32'h0, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0,
                    1'b0, 32'h0, 1'b0, 32'h0);
        end
        check_cnt("bc_sat", 4'hF, 4'd10);

        // MISPREDICT_COUNT saturation: 6 mispredicts from 10
        for (int i = 0; i < 6; i++) begin
            ex_step("mc_sat", 1'b1, 32'h400, 32'h40, 32'h0, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0,
                    1'b1, 32'h440, 1'b1, 32'h404);
        end
        check_cnt("mc_sat", 4'hF, 4'hF);

        // RESET together with a mispredicting EX: FLUSH suppressed, all cleared
        RESET = 1'b1;
        ex_step("rst_mid", 1'b1, 32'h200, 32'h0, 32'h3000, 2'b10, 3'b000, 1'b0, 1'b0, 1'b0,
                1'b0, 32'h0, 1'b0, 32'h0);
        RESET = 1'b0;
        check_cnt("rst_mid", 4'd0, 4'd0);
        check_pred("rst_mid", 32'h200, 1'b0, 32'h0);
        check_pred("rst_mid_304", 32'h304, 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
